// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared seven-segment definitions for the stopwatch display path.
//   seg_t       : segment vector, bit 0 = a ... bit 6 = g, active-high.
//   hex_t       : 4-bit hex digit code.
//   SEG_0..SEG_F: standard hex glyphs (6 and 9 with tails, lowercase b and d).
//   SEG_BLANK   : all segments off.
//   NUM_DIGITS  : number of multiplexed digit positions.
// The encoder helper is the forward mapping used by the stopwatch driver; the
// glyph decoder is its exact inverse and uses the same constants.
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] hex_t;

  localparam int NUM_DIGITS = 8;

  //                               gfedcba
  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b1111100;
  localparam seg_t SEG_C     = 7'b0111001;
  localparam seg_t SEG_D     = 7'b1011110;
  localparam seg_t SEG_E     = 7'b1111001;
  localparam seg_t SEG_F     = 7'b1110001;
  localparam seg_t SEG_BLANK = 7'b0000000;

  // Forward mapping hex -> glyph, as used by the stopwatch digit driver.
  function automatic seg_t seg7_encode(input hex_t code);
    seg_t seg;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// -----------------------------------------------------------------------------
// seg7_glyph_decode
// Combinational inverse of the stopwatch digit encoder.
//   i_seg   : active-high segment pattern (bit 0 = a ... bit 6 = g).
//   o_code  : decoded hex code (0 for blank and for illegal patterns).
//   o_blank : pattern is all segments off.
//   o_legal : pattern is one of the 16 hex glyphs or blank.
// -----------------------------------------------------------------------------
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  seg_t i_seg,
  output hex_t o_code,
  output logic o_blank,
  output logic o_legal
);

  always_comb begin
    o_code  = 4'h0;
    o_blank = 1'b0;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0:     o_code = 4'h0;
      SEG_1:     o_code = 4'h1;
      SEG_2:     o_code = 4'h2;
      SEG_3:     o_code = 4'h3;
      SEG_4:     o_code = 4'h4;
      SEG_5:     o_code = 4'h5;
      SEG_6:     o_code = 4'h6;
      SEG_7:     o_code = 4'h7;
      SEG_8:     o_code = 4'h8;
      SEG_9:     o_code = 4'h9;
      SEG_A:     o_code = 4'hA;
      SEG_B:     o_code = 4'hB;
      SEG_C:     o_code = 4'hC;
      SEG_D:     o_code = 4'hD;
      SEG_E:     o_code = 4'hE;
      SEG_F:     o_code = 4'hF;
      SEG_BLANK: o_blank = 1'b1;
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Monitors a multiplexed seven-segment scan bus and rebuilds the 8-digit frame.
// Parameters:
//   SETTLE_CYCLES : consecutive identical samples needed before capture (1..255).
//   ACTIVE_LOW    : 1 = anodes and segments are active-low on the bus.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset.
//   anode_assert  : one-hot digit select (bus polarity), bit i = digit i.
//   segs          : segment drive (bus polarity), segs[0] = a ... segs[6] = g.
//   digits        : last complete frame, digit i at [4i+3:4i].
//   blanks        : last complete frame, bit i = digit i was all segments off.
//   frame_done    : one-cycle pulse when digits/blanks update.
//   seg_err       : one-cycle pulse when a settled pattern is not a legal glyph.
//   anode_err     : one-cycle pulse on the first cycle of a multi-anode run.
// -----------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  anode_assert,
  input  logic [6:0]  segs,
  output logic [31:0] digits,
  output logic [7:0]  blanks,
  output logic        frame_done,
  output logic        seg_err,
  output logic        anode_err
);

  localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Bus values normalized to active-high before registering.
  logic [7:0] w_an_in;
  seg_t       w_seg_in;

  assign w_an_in  = ACTIVE_LOW ? ~anode_assert : anode_assert;
  assign w_seg_in = ACTIVE_LOW ? ~segs : segs;

  // Input stage (same clock domain, single register).
  logic [7:0] r_an;
  seg_t       r_segs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an   <= '0;
      r_segs <= SEG_BLANK;
    end else begin
      r_an   <= w_an_in;
      r_segs <= w_seg_in;
    end
  end

  // Anode classification on the registered value.
  logic       w_any;
  logic       w_multi;
  logic       w_one_hot;
  logic [2:0] w_idx;

  assign w_any     = (r_an != 8'h00);
  assign w_multi   = ((r_an & (r_an - 8'd1)) != 8'h00);
  assign w_one_hot = w_any && !w_multi;

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_an[i]) w_idx = 3'(i);
    end
  end

  // The sample being registered this edge is compared with the one registered
  // last edge, so the count reaches SETTLE_CYCLES on the edge that registers
  // the SETTLE_CYCLES-th repeat of the newly registered value.
  logic       w_same;
  logic [7:0] r_cnt;
  logic       w_capture;

  assign w_same    = (w_an_in == r_an) && (w_seg_in == r_segs);
  assign w_capture = w_one_hot && w_same && (r_cnt == SETTLE_LAST);

  // Count parks at SETTLE_MAX after capture, so a dwell captures only once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_one_hot || !w_same) begin
      r_cnt <= '0;
    end else if (r_cnt != SETTLE_MAX) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Glyph decode of the settled pattern.
  hex_t w_code;
  logic w_blank;
  logic w_legal;

  seg7_glyph_decode u_glyph_decode (
    .i_seg   (r_segs),
    .o_code  (w_code),
    .o_blank (w_blank),
    .o_legal (w_legal)
  );

  // Working frame and the set of positions captured so far.
  logic [31:0] r_work_code;
  logic [7:0]  r_work_blank;
  logic [7:0]  r_seen;
  logic [31:0] w_work_code_nx;
  logic [7:0]  w_work_blank_nx;
  logic [7:0]  w_seen_nx;
  logic        w_store;
  logic        w_frame_complete;

  assign w_store = w_capture && w_legal;

  always_comb begin
    w_work_code_nx  = r_work_code;
    w_work_blank_nx = r_work_blank;
    w_seen_nx       = r_seen;
    if (w_store) begin
      w_work_code_nx[{w_idx, 2'b00} +: 4] = w_code;
      w_work_blank_nx[w_idx]              = w_blank;
      w_seen_nx[w_idx]                    = 1'b1;
    end
  end

  // Includes the capture made on this very edge.
  assign w_frame_complete = (w_seen_nx == 8'hFF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_work_code  <= '0;
      r_work_blank <= '0;
      r_seen       <= '0;
    end else begin
      r_work_code  <= w_work_code_nx;
      r_work_blank <= w_work_blank_nx;
      r_seen       <= w_frame_complete ? 8'h00 : w_seen_nx;
    end
  end

  // Published frame; only moves together with frame_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits     <= '0;
      blanks     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_complete;
      if (w_frame_complete) begin
        digits <= w_work_code_nx;
        blanks <= w_work_blank_nx;
      end
    end
  end

  // Error pulses. anode_err fires on the rising edge of a multi-anode run.
  logic r_multi_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_multi_d <= 1'b0;
      anode_err <= 1'b0;
      seg_err   <= 1'b0;
    end else begin
      r_multi_d <= w_multi;
      anode_err <= w_multi && !r_multi_d;
      seg_err   <= w_capture && !w_legal;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed bench for seg7_scan_decoder with default parameters (settle 4,
// active-low bus). Inputs change on the falling edge; outputs and pulse
// counters are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  anode_assert;
  logic [6:0]  segs;
  logic [31:0] digits;
  logic [7:0]  blanks;
  logic        frame_done;
  logic        seg_err;
  logic        anode_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int se_cnt   = 0;
  int ae_cnt   = 0;

  // Independent glyph table, gfedcba active-high.
  localparam logic [6:0] ILLEGAL_AH = 7'b1001001;

  seg7_scan_decoder dut (
    .clock        (clock),
    .reset        (reset),
    .anode_assert (anode_assert),
    .segs         (segs),
    .digits       (digits),
    .blanks       (blanks),
    .frame_done   (frame_done),
    .seg_err      (seg_err),
    .anode_err    (anode_err)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  // Pulse counters
  always @(negedge clock) begin
    if (frame_done) fd_cnt++;
    if (seg_err)    se_cnt++;
    if (anode_err)  ae_cnt++;
  end

  function automatic logic [6:0] enc(input logic [3:0] h);
    case (h)
      4'h0: enc = 7'h3F; 4'h1: enc = 7'h06; 4'h2: enc = 7'h5B; 4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66; 4'h5: enc = 7'h6D; 4'h6: enc = 7'h7D; 4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F; 4'h9: enc = 7'h6F; 4'hA: enc = 7'h77; 4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39; 4'hD: enc = 7'h5E; 4'hE: enc = 7'h79; default: enc = 7'h71;
    endcase
  endfunction

  // Driver tasks (called at a falling edge, return at a falling edge)
  task automatic drive_raw(input logic [7:0] an_ah, input logic [6:0] seg_ah, input int cycles);
    anode_assert = ~an_ah;
    segs         = ~seg_ah;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic drive_digit(input int idx, input logic [6:0] seg_ah, input int cycles);
    logic [7:0] one;
    one = 8'h01;
    drive_raw(one << idx, seg_ah, cycles);
  endtask

  task automatic drive_value(input int idx, input logic [31:0] val, input int cycles);
    drive_digit(idx, enc(val[4*idx +: 4]), cycles);
  endtask

  task automatic drive_idle(input int cycles);
    drive_raw(8'h00, 7'h00, cycles);
  endtask

  // Tests
  task automatic test_reset();
    n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL reset_digits: got %h expected %h", digits, 32'h0); end
    n_checks++; if (blanks !== 8'h0) begin n_fail++; $display("FAIL reset_blanks: got %h expected %h", blanks, 8'h0); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL reset_seg_err: got %b expected 0", seg_err); end
    n_checks++; if (anode_err !== 1'b0) begin n_fail++; $display("FAIL reset_anode_err: got %b expected 0", anode_err); end
  endtask

  task automatic test_normal_scan();
    int fd0;
    fd0 = fd_cnt;
    for (int i = 0; i < 7; i++) drive_value(i, 32'h0000_1234, 10);
    n_checks++; if (fd_cnt !== fd0) begin n_fail++; $display("FAIL normal_early_frame: got %0d frames expected %0d", fd_cnt - fd0, 0); end
    n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL normal_digits_early: got %h expected %h", digits, 32'h0); end
    drive_value(7, 32'h0000_1234, 10);
    drive_idle(2);
    n_checks++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL normal_frame_count: got %0d expected %0d", fd_cnt - fd0, 1); end
    n_checks++; if (digits !== 32'h0000_1234) begin n_fail++; $display("FAIL normal_digits: got %h expected %h", digits, 32'h0000_1234); end
    n_checks++; if (blanks !== 8'h00) begin n_fail++; $display("FAIL normal_blanks: got %h expected %h", blanks, 8'h00); end
    n_checks++; if (se_cnt !== 0) begin n_fail++; $display("FAIL normal_seg_err: got %0d expected 0", se_cnt); end
    n_checks++; if (ae_cnt !== 0) begin n_fail++; $display("FAIL normal_anode_err: got %0d expected 0", ae_cnt); end
  endtask

  task automatic test_glitch();
    int fd0;
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) drive_value(i, 32'h89AB_CDEF, 10);
    drive_digit(2, enc(4'h8), 3);
    for (int i = 3; i < 8; i++) drive_value(i, 32'h89AB_CDEF, 10);
    drive_idle(2);
    n_checks++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL glitch_frame_count: got %0d expected %0d", fd_cnt - fd0, 1); end
    n_checks++; if (digits !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL glitch_digits: got %h expected %h", digits, 32'h89AB_CDEF); end
  endtask

  task automatic test_multi_anode();
    int fd0;
    int ae0;
    fd0 = fd_cnt;
    ae0 = ae_cnt;
    for (int i = 0; i < 4; i++) drive_value(i, 32'h1357_2468, 10);
    drive_raw(8'b0000_0011, enc(4'h0), 6);
    drive_idle(2);
    n_checks++; if (ae_cnt !== ae0 + 1) begin n_fail++; $display("FAIL multi_anode_err: got %0d expected %0d", ae_cnt - ae0, 1); end
    n_checks++; if (fd_cnt !== fd0) begin n_fail++; $display("FAIL multi_no_frame: got %0d expected %0d", fd_cnt - fd0, 0); end
    for (int i = 4; i < 8; i++) drive_value(i, 32'h1357_2468, 10);
    drive_idle(2);
    n_checks++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL multi_frame_count: got %0d expected %0d", fd_cnt - fd0, 1); end
    n_checks++; if (digits !== 32'h1357_2468) begin n_fail++; $display("FAIL multi_digits: got %h expected %h", digits, 32'h1357_2468); end
    n_checks++; if (ae_cnt !== ae0 + 1) begin n_fail++; $display("FAIL multi_anode_err_total: got %0d expected %0d", ae_cnt - ae0, 1); end
  endtask

  task automatic test_illegal_glyph();
    int fd0;
    int se0;
    fd0 = fd_cnt;
    se0 = se_cnt;
    for (int i = 0; i < 8; i++) if (i != 5) drive_value(i, 32'hF0E1_D2C3, 10);
    drive_digit(5, ILLEGAL_AH, 10);
    drive_idle(2);
    n_checks++; if (se_cnt !== se0 + 1) begin n_fail++; $display("FAIL illegal_seg_err: got %0d expected %0d", se_cnt - se0, 1); end
    n_checks++; if (fd_cnt !== fd0) begin n_fail++; $display("FAIL illegal_no_frame: got %0d expected %0d", fd_cnt - fd0, 0); end
    drive_value(5, 32'hF0E1_D2C3, 10);
    drive_idle(2);
    n_checks++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL illegal_frame_count: got %0d expected %0d", fd_cnt - fd0, 1); end
    n_checks++; if (digits !== 32'hF0E1_D2C3) begin n_fail++; $display("FAIL illegal_digits: got %h expected %h", digits, 32'hF0E1_D2C3); end
    n_checks++; if (se_cnt !== se0 + 1) begin n_fail++; $display("FAIL illegal_seg_err_total: got %0d expected %0d", se_cnt - se0, 1); end
  endtask

  task automatic test_blank_digit();
    int fd0;
    fd0 = fd_cnt;
    for (int i = 0; i < 7; i++) drive_value(i, 32'h0765_4321, 10);
    drive_digit(7, 7'h00, 10);
    drive_idle(2);
    n_checks++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL blank_frame_count: got %0d expected %0d", fd_cnt - fd0, 1); end
    n_checks++; if (blanks !== 8'h80) begin n_fail++; $display("FAIL blank_blanks: got %h expected %h", blanks, 8'h80); end
    n_checks++; if (digits[31:28] !== 4'h0) begin n_fail++; $display("FAIL blank_code: got %h expected %h", digits[31:28], 4'h0); end
    n_checks++; if (digits !== 32'h0765_4321) begin n_fail++; $display("FAIL blank_digits: got %h expected %h", digits, 32'h0765_4321); end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    for (int i = 0; i < 5; i++) drive_value(i, 32'hAAAA_AAAA, 10);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL rst_mid_digits: got %h expected %h", digits, 32'h0); end
    n_checks++; if (blanks !== 8'h0) begin n_fail++; $display("FAIL rst_mid_blanks: got %h expected %h", blanks, 8'h0); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_frame_done: got %b expected 0", frame_done); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    fd0 = fd_cnt;
    for (int i = 5; i < 8; i++) drive_value(i, 32'hC0FF_EE42, 10);
    drive_idle(2);
    n_checks++; if (fd_cnt !== fd0) begin n_fail++; $display("FAIL rst_mid_no_stale_frame: got %0d expected %0d", fd_cnt - fd0, 0); end
    for (int i = 0; i < 5; i++) drive_value(i, 32'hC0FF_EE42, 10);
    drive_idle(2);
    n_checks++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL rst_mid_frame_count: got %0d expected %0d", fd_cnt - fd0, 1); end
    n_checks++; if (digits !== 32'hC0FF_EE42) begin n_fail++; $display("FAIL rst_mid_digits_after: got %h expected %h", digits, 32'hC0FF_EE42); end
    n_checks++; if (blanks !== 8'h00) begin n_fail++; $display("FAIL rst_mid_blanks_after: got %h expected %h", blanks, 8'h00); end
  endtask

  initial begin
    reset        = 1'b1;
    anode_assert = 8'hFF;
    segs         = 7'h7F;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    drive_idle(2);
    test_normal_scan();
    test_glitch();
    test_multi_anode();
    test_illegal_glyph();
    test_blank_digit();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
